// File: rtl/tt_sweep_pkg.sv
// ---------------------------------------------------------------------------
// tt_sweep_pkg
// Shared definitions for the truth-table sweep sequencer:
//   state_t  - sequencer FSM states
//   tt_len() - truth-table length for a given input count (2^n)
// ---------------------------------------------------------------------------
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int tt_len(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// tt_sweep_ctrl_if
// Bundle between the sweep sequencer and the harness around it.
//   start          request a sweep
//   vec_o          vector driven to both netlists
//   ya_i / yb_i    outputs of netlist A / B
//   busy, done     sweep status (done is a one-cycle pulse)
//   tt_a           truth table of netlist A
//   mismatch, mis_count, first_mis_idx   A-vs-B comparison results
// slave modport: the sequencer. master modport: the harness.
// ---------------------------------------------------------------------------
interface tt_sweep_ctrl_if
  import tt_sweep_pkg::*;
#(
  parameter int N_IN = 6
);
  localparam int T = tt_len(N_IN);

  logic            start;
  logic [N_IN-1:0] vec_o;
  logic            ya_i;
  logic            yb_i;
  logic            busy;
  logic            done;
  logic [T-1:0]    tt_a;
  logic            mismatch;
  logic [N_IN:0]   mis_count;
  logic [N_IN-1:0] first_mis_idx;

  modport slave (
    input  start, ya_i, yb_i,
    output vec_o, busy, done, tt_a, mismatch, mis_count, first_mis_idx
  );

  modport master (
    output start, ya_i, yb_i,
    input  vec_o, busy, done, tt_a, mismatch, mis_count, first_mis_idx
  );

endinterface

// File: rtl/tt_mis_tracker.sv
// ---------------------------------------------------------------------------
// tt_mis_tracker
// Accumulates the A-vs-B comparison over one sweep.
//   clk, rst_n        clock, synchronous active-low reset
//   clear_i           zero all results (sweep start)
//   sample_en_i       compare ya_i/yb_i for minterm idx_i this cycle
//   mismatch_o        any differing minterm seen
//   mis_count_o       number of differing minterms (0..2^N_IN)
//   first_mis_idx_o   lowest differing minterm (0 if none)
// ---------------------------------------------------------------------------
module tt_mis_tracker #(
  parameter int N_IN = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            sample_en_i,
  input  logic [N_IN-1:0] idx_i,
  input  logic            ya_i,
  input  logic            yb_i,
  output logic            mismatch_o,
  output logic [N_IN:0]   mis_count_o,
  output logic [N_IN-1:0] first_mis_idx_o
);
  localparam logic [N_IN:0] CNT_ONE = (N_IN + 1)'(1);

  logic            mismatch_q, mismatch_d;
  logic [N_IN:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] first_q, first_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
      cnt_q      <= '0;
      first_q    <= '0;
    end else begin
      mismatch_q <= mismatch_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
    end
  end

  // Minterms arrive in ascending order, so the first hit is the lowest index.
  always_comb begin
    mismatch_d = mismatch_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    if (clear_i) begin
      mismatch_d = 1'b0;
      cnt_d      = '0;
      first_d    = '0;
    end else if (sample_en_i && (ya_i != yb_i)) begin
      cnt_d = cnt_q + CNT_ONE;
      if (!mismatch_q) begin
        mismatch_d = 1'b1;
        first_d    = idx_i;
      end
    end
  end

  assign mismatch_o      = mismatch_q;
  assign mis_count_o     = cnt_q;
  assign first_mis_idx_o = first_q;

endmodule

// File: rtl/tt_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tt_sweep_ctrl
// Exhaustively sweeps all 2^N_IN input vectors of two combinational
// netlists, waits SETTLE cycles per vector, samples both outputs, builds
// the truth table of A and compares A against B.
//   clk, rst_n   clock, synchronous active-low reset
//   bus          tt_sweep_ctrl_if slave: start, vec_o, ya_i, yb_i, busy,
//                done, tt_a, mismatch, mis_count, first_mis_idx
// ---------------------------------------------------------------------------
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int N_IN   = 6,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  tt_sweep_ctrl_if.slave bus
);
  localparam int T      = tt_len(N_IN);
  localparam int WCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(SETTLE - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [N_IN-1:0]   IDX_LAST  = '1;
  localparam logic [N_IN-1:0]   IDX_ONE   = N_IN'(1);

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [T-1:0]    tt_a_q, tt_a_d;
  logic            clear, sample_en, busy, done;
  logic            mismatch;
  logic [N_IN:0]   mis_count;
  logic [N_IN-1:0] first_mis_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q  <= '0;
      wcnt_q <= '0;
      tt_a_q <= '0;
    end else begin
      idx_q  <= idx_d;
      wcnt_q <= wcnt_d;
      tt_a_q <= tt_a_d;
    end
  end

  // idx is never advanced past IDX_LAST: SAMPLE exits to DONE instead, so
  // vec_o keeps showing the last vector while idle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    tt_a_d  = tt_a_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          tt_a_d  = '0;
          idx_d   = '0;
          wcnt_d  = WCNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wcnt_q == '0) state_d = SAMPLE;
        else              wcnt_d  = wcnt_q - WCNT_ONE;
      end
      SAMPLE: begin
        tt_a_d[idx_q] = bus.ya_i;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          wcnt_d  = WCNT_LOAD;
          state_d = WAIT;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == WAIT) || (state_q == SAMPLE);
    done      = (state_q == DONE);
    clear     = (state_q == IDLE) && bus.start;
    sample_en = (state_q == SAMPLE);
  end

  tt_mis_tracker #(
    .N_IN(N_IN)
  ) u_mis (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear_i        (clear),
    .sample_en_i    (sample_en),
    .idx_i          (idx_q),
    .ya_i           (bus.ya_i),
    .yb_i           (bus.yb_i),
    .mismatch_o     (mismatch),
    .mis_count_o    (mis_count),
    .first_mis_idx_o(first_mis_idx)
  );

  assign bus.vec_o         = idx_q;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.tt_a          = tt_a_q;
  assign bus.mismatch      = mismatch;
  assign bus.mis_count     = mis_count;
  assign bus.first_mis_idx = first_mis_idx;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tt_sweep_ctrl
// Bench for tt_sweep_ctrl: dut0 uses the defaults (N_IN=6, SETTLE=1) with
// combinational stand-in netlists; dut1 uses SETTLE=3 with netlists that
// respond through a 2-cycle register delay. Expected results are queued
// when a sweep is started and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_tt_sweep_ctrl;

  typedef struct {
    logic [63:0] tt;
    logic        mis;
    logic [6:0]  cnt;
    logic [5:0]  first;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  int   mode0 = 0;
  logic ya0, yb0;
  logic d1a = 1'b0, d2a = 1'b0, d1b = 1'b0, d2b = 1'b0;

  int   total = 0;
  int   bad = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;

  tt_sweep_ctrl_if #(.N_IN(6)) bus0 ();
  tt_sweep_ctrl_if #(.N_IN(6)) bus1 ();

  tt_sweep_ctrl #(.N_IN(6), .SETTLE(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  tt_sweep_ctrl #(.N_IN(6), .SETTLE(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always_comb begin
    ya0 = 1'b0;
    yb0 = 1'b0;
    case (mode0)
      0: begin ya0 = bus0.vec_o[0]; yb0 = bus0.vec_o[0]; end
      1: begin ya0 = bus0.vec_o[0]; yb0 = 1'b0; end
      2: begin ya0 = &bus0.vec_o;   yb0 = 1'b0; end
      default: begin ya0 = 1'b0; yb0 = 1'b0; end
    endcase
  end

  always @(posedge clk) begin
    d1a <= bus1.vec_o[5] ^ bus1.vec_o[0];
    d2a <= d1a;
    d1b <= bus1.vec_o[5] ^ bus1.vec_o[0];
    d2b <= d1b;
  end

  assign bus0.start = start0;
  assign bus0.ya_i  = ya0;
  assign bus0.yb_i  = yb0;
  assign bus1.start = start1;
  assign bus1.ya_i  = d2a;
  assign bus1.yb_i  = d2b;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  function automatic exp_t exp_of(input int m);
    exp_t e;
    case (m)
      0:       begin e.tt = 64'hAAAA_AAAA_AAAA_AAAA; e.mis = 1'b0; e.cnt = 7'd0;  e.first = 6'd0;  end
      1:       begin e.tt = 64'hAAAA_AAAA_AAAA_AAAA; e.mis = 1'b1; e.cnt = 7'd32; e.first = 6'd1;  end
      2:       begin e.tt = 64'h8000_0000_0000_0000; e.mis = 1'b1; e.cnt = 7'd1;  e.first = 6'd63; end
      default: begin e.tt = 64'h5555_5555_AAAA_AAAA; e.mis = 1'b0; e.cnt = 7'd0;  e.first = 6'd0;  end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus0.done) begin
      chk("sb0_has_exp", 64'(sb0.size() != 0), 64'd1);
      if (sb0.size() != 0) begin
        e0 = sb0.pop_front();
        chk("sb0_tt_a", bus0.tt_a, e0.tt);
        chk("sb0_mismatch", 64'(bus0.mismatch), 64'(e0.mis));
        chk("sb0_mis_count", 64'(bus0.mis_count), 64'(e0.cnt));
        chk("sb0_first_idx", 64'(bus0.first_mis_idx), 64'(e0.first));
      end
    end
    if (bus1.done) begin
      chk("sb1_has_exp", 64'(sb1.size() != 0), 64'd1);
      if (sb1.size() != 0) begin
        e1 = sb1.pop_front();
        chk("sb1_tt_a", bus1.tt_a, e1.tt);
        chk("sb1_mismatch", 64'(bus1.mismatch), 64'(e1.mis));
        chk("sb1_mis_count", 64'(bus1.mis_count), 64'(e1.cnt));
        chk("sb1_first_idx", 64'(bus1.first_mis_idx), 64'(e1.first));
      end
    end
  end

  // One start pulse on dut0; checks latency and busy length.
  task automatic sweep0(input int m);
    int cyc;
    int bcnt;
    mode0 = m;
    sb0.push_back(exp_of(m));
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("busy_rise", 64'(bus0.busy), 64'd1);
    chk("vec_first", 64'(bus0.vec_o), 64'd0);
    cyc  = 1;
    bcnt = 1;
    while (!bus0.done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bus0.busy) bcnt++;
    end
    chk("done_latency", 64'(cyc), 64'd129);
    chk("busy_cycles", 64'(bcnt), 64'd128);
    chk("vec_hold", 64'(bus0.vec_o), 64'd63);
  endtask

  initial begin
    int cyc;
    int bcnt;
    int dcnt;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus0.busy), 64'd0);
    chk("rst_done", 64'(bus0.done), 64'd0);
    chk("rst_vec", 64'(bus0.vec_o), 64'd0);
    chk("rst_tt_a", bus0.tt_a, 64'd0);
    chk("rst_mismatch", 64'(bus0.mismatch), 64'd0);
    chk("rst_mis_count", 64'(bus0.mis_count), 64'd0);
    chk("rst_first_idx", 64'(bus0.first_mis_idx), 64'd0);
    rst_n = 1'b1;

    // Reset in the middle of a sweep: no done, no queued expectation.
    mode0 = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (39) @(negedge clk);
    chk("pre_rst_busy", 64'(bus0.busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", 64'(bus0.busy), 64'd0);
    chk("midrst_vec", 64'(bus0.vec_o), 64'd0);
    chk("midrst_tt_a", bus0.tt_a, 64'd0);
    chk("midrst_mis_count", 64'(bus0.mis_count), 64'd0);
    dcnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (bus0.done) dcnt++;
    end
    chk("midrst_no_done", 64'(dcnt), 64'd0);

    sweep0(0);
    sweep0(1);
    sweep0(2);

    // Start held high: each restart happens from IDLE, one cycle after done.
    mode0 = 1;
    for (int i = 0; i < 3; i++) sb0.push_back(exp_of(1));
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cyc = 1;
      while (!bus0.done && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
      chk("b2b_latency", 64'(cyc), 64'd129);
      if (i == 2) start0 = 1'b0;
      @(negedge clk);
      chk("b2b_idle_busy", 64'(bus0.busy), 64'd0);
      chk("b2b_idle_done", 64'(bus0.done), 64'd0);
      if (i < 2) begin
        @(negedge clk);
        chk("b2b_restart_busy", 64'(bus0.busy), 64'd1);
        chk("b2b_clr_tt_a", bus0.tt_a, 64'd0);
        chk("b2b_clr_count", 64'(bus0.mis_count), 64'd0);
        chk("b2b_clr_first", 64'(bus0.first_mis_idx), 64'd0);
        chk("b2b_clr_mismatch", 64'(bus0.mismatch), 64'd0);
      end
    end
    @(negedge clk);
    chk("b2b_stays_idle", 64'(bus0.busy), 64'd0);

    // SETTLE=3 with delayed netlist responses.
    sb1.push_back(exp_of(3));
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("s3_busy_rise", 64'(bus1.busy), 64'd1);
    cyc  = 1;
    bcnt = 1;
    while (!bus1.done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (bus1.busy) bcnt++;
    end
    chk("s3_busy_cycles", 64'(bcnt), 64'd256);
    chk("s3_done_latency", 64'(cyc), 64'd257);

    repeat (3) @(negedge clk);
    chk("sb0_drained", 64'(sb0.size()), 64'd0);
    chk("sb1_drained", 64'(sb1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
